// File: rtl/piso_pkg.sv
// piso_pkg -- shared definitions for the PISO serializer.
//
// Holds the FSM state encoding used by piso_serializer. The PARITY state
// exists only when the optional parity feature is built in.
//
// Configuration macro: PISO_PARITY_EN (adds the trailing even-parity bit).
package piso_pkg;

  localparam logic [1:0] ST_IDLE_ENC   = 2'b00;
  localparam logic [1:0] ST_SHIFT_ENC  = 2'b01;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] ST_PARITY_ENC = 2'b10;
`endif

  typedef enum logic [1:0] {
`ifdef PISO_PARITY_EN
    ST_PARITY = ST_PARITY_ENC,
`endif
    ST_IDLE   = ST_IDLE_ENC,
    ST_SHIFT  = ST_SHIFT_ENC
  } piso_state_e;

endpackage : piso_pkg

// File: rtl/piso_bit_counter.sv
// piso_bit_counter -- parametrised modulo counter.
//
// Counts 0..MOD-1 while en_i is high and wraps to 0 after MOD-1.
// clr_i forces the count to 0 and has priority over en_i.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (count -> 0)
//   clr_i    synchronous clear
//   en_i     count enable
//   tc_o     terminal-count flag, high while count == MOD-1
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int MOD = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (MOD > 1) ? $clog2(MOD) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o = (cnt_q == CW'(MOD - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : piso_bit_counter

// File: rtl/piso_serializer.sv
// piso_serializer -- parallel-in / serial-out shifter with valid/ready load.
//
// A word accepted on load_valid && load_ready is sent one bit per consumed
// cycle (shift_en=1) starting the cycle after accept. shift_en=0 stalls the
// current bit. done pulses the cycle after the final frame bit is consumed.
// A new word may be accepted on that final-bit cycle for a gapless stream.
//
// Parameters:
//   WIDTH      parallel word width (2..32)
//   MSB_FIRST  1: bit WIDTH-1 first, 0: bit 0 first
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   load_valid    data_in holds a word
//   load_ready    word accepted this cycle when load_valid is high
//   data_in       parallel word
//   shift_en      downstream consumes serial_out this cycle
//   serial_out    current serial bit (0 when serial_valid=0)
//   serial_valid  serial_out carries a frame bit
//   busy          frame in progress
//   done          one-cycle end-of-frame pulse
//
// Configuration macro: PISO_PARITY_EN -- appends one even-parity bit
// (XOR of the data bits) after the data, frame length WIDTH+1.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  // Output end of the shift register.
  localparam int OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

  piso_state_e      state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             serial_out_q;
  logic             serial_valid_q;
  logic             done_q;
`ifdef PISO_PARITY_EN
  logic             parity_q;
`endif

  logic last_bit;
  logic advance;
  logic frame_end;
  logic accept;

  // Shift toward the output end, vacated bit filled with 0.
  assign shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

  assign advance = (state_q == ST_SHIFT) && shift_en;

`ifdef PISO_PARITY_EN
  assign frame_end = (state_q == ST_PARITY) && shift_en;
`else
  assign frame_end = advance && last_bit;
`endif

  // Ready in IDLE and on the consumed final bit, enabling back-to-back frames.
  assign load_ready = (state_q == ST_IDLE) || frame_end;
  assign accept     = load_valid && load_ready;

  piso_bit_counter #(
    .MOD (WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (accept || frame_end),
    .en_i    (advance && !last_bit),
    .tc_o    (last_bit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      shreg_q        <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      done_q         <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q       <= 1'b0;
`endif
    end else begin
      done_q <= frame_end;
      if (accept) begin
        state_q        <= ST_SHIFT;
        shreg_q        <= data_in;
        serial_out_q   <= data_in[OUT_IDX];
        serial_valid_q <= 1'b1;
`ifdef PISO_PARITY_EN
        parity_q       <= 1'b0;
`endif
      end else if (frame_end) begin
        state_q        <= ST_IDLE;
        shreg_q        <= '0;
        serial_out_q   <= 1'b0;
        serial_valid_q <= 1'b0;
      end else if (advance) begin
`ifdef PISO_PARITY_EN
        // Accumulate every consumed data bit; the last one is folded in
        // directly when switching to the parity bit.
        parity_q <= parity_q ^ serial_out_q;
        if (last_bit) begin
          state_q      <= ST_PARITY;
          serial_out_q <= parity_q ^ serial_out_q;
        end else begin
          shreg_q      <= shreg_d;
          serial_out_q <= shreg_d[OUT_IDX];
        end
`else
        shreg_q      <= shreg_d;
        serial_out_q <= shreg_d[OUT_IDX];
`endif
      end
    end
  end

  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer -- bench for piso_serializer (WIDTH=8), one instance per
// bit order driven by the same stimulus, compared each cycle against a
// queue-based frame model plus table vectors and hand-written sequences.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = 8 + PB;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load_valid;
  logic       shift_en;
  logic [7:0] data_in;

  logic rdy_m, out_m, val_m, busy_m, done_m;
  logic rdy_l, out_l, val_l, busy_l, done_l;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_ready(rdy_m),
    .data_in(data_in), .shift_en(shift_en), .serial_out(out_m),
    .serial_valid(val_m), .busy(busy_m), .done(done_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_ready(rdy_l),
    .data_in(data_in), .shift_en(shift_en), .serial_out(out_l),
    .serial_valid(val_l), .busy(busy_l), .done(done_l)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bits still to be sent, in transmission order.
  bit qm[$];
  bit ql[$];
  bit done_exp = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] seq_m;  // expected stream, first bit on the left
    logic [7:0] seq_l;
    logic       par;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      qm.push_back(d[7-i]);
      ql.push_back(d[i]);
    end
    if (PB == 1) begin
      qm.push_back(^d);
      ql.push_back(^d);
    end
  endtask

  // Compare every output of both instances with the model at the falling edge.
  task automatic sample();
    bit v, om, ol, rdy;
    @(negedge clk);
    v   = (qm.size() != 0);
    om  = 1'b0;
    ol  = 1'b0;
    if (v) begin
      om = qm[0];
      ol = ql[0];
    end
    rdy = !v || (qm.size() == 1 && shift_en);
    chk("m_valid", val_m, v);
    chk("m_out", out_m, om);
    chk("m_busy", busy_m, v);
    chk("m_ready", rdy_m, rdy);
    chk("m_done", done_m, done_exp);
    chk("l_valid", val_l, v);
    chk("l_out", out_l, ol);
    chk("l_busy", busy_l, v);
    chk("l_ready", rdy_l, rdy);
    chk("l_done", done_l, done_exp);
  endtask

  // Apply the clock edge to the model, then advance to just after the edge.
  task automatic advance();
    bit v, rdy, cons;
    v   = (qm.size() != 0);
    rdy = !v || (qm.size() == 1 && shift_en);
    if (!reset_n) begin
      qm.delete();
      ql.delete();
      done_exp = 1'b0;
    end else begin
      cons = v && shift_en;
      if (cons) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      done_exp = cons && (qm.size() == 0);
      if (load_valid && rdy) push_frame(data_in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic accept_word(input logic [7:0] d);
    load_valid = 1'b1;
    data_in    = d;
    shift_en   = 1'b1;
    cycle();
    load_valid = 1'b0;
    data_in    = 8'($urandom);
  endtask

  initial begin
    int dk;
    int ndone;
    logic [17:0] bb;

    tbl[0] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0};
    tbl[1] = '{8'h01, 8'b00000001, 8'b10000000, 1'b1};
    tbl[2] = '{8'hF0, 8'b11110000, 8'b00001111, 1'b0};
    tbl[3] = '{8'h07, 8'b00000111, 8'b11100000, 1'b1};
    tbl[4] = '{8'h3C, 8'b00111100, 8'b00111100, 1'b0};
    tbl[5] = '{8'h80, 8'b10000000, 8'b00000001, 1'b1};

    reset_n    = 1'b0;
    load_valid = 1'b1;
    shift_en   = 1'b0;
    data_in    = 8'h5A;
    // Words offered during reset must be ignored.
    cycle();
    cycle();
    reset_n    = 1'b1;
    load_valid = 1'b0;
    cycle();

    // Table vectors, shift_en held high.
    for (int v = 0; v < 6; v++) begin
      accept_word(tbl[v].data);
      for (int i = 0; i < 8; i++) begin
        sample();
        chk("tbl_bit_m", out_m, tbl[v].seq_m[7-i]);
        chk("tbl_bit_l", out_l, tbl[v].seq_l[7-i]);
        advance();
      end
      if (PB == 1) begin
        sample();
        chk("tbl_par_m", out_m, tbl[v].par);
        chk("tbl_par_l", out_l, tbl[v].par);
        advance();
      end
      sample();
      chk("tbl_done_m", done_m, 1'b1);
      chk("tbl_done_l", done_l, 1'b1);
      advance();
      cycle();
    end

    // Stall: shift_en low for 3 cycles while bit 2 is shown.
    accept_word(8'hF0);
    dk = -1;
    for (int k = 1; k <= 20; k++) begin
      shift_en = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
      sample();
      if (k >= 3 && k <= 6) begin
        chk("stall_hold_m", out_m, 1'b1);
        chk("stall_hold_l", out_l, 1'b0);
      end
      if (done_m && dk < 0) dk = k;
      advance();
    end
    chk_int("stall_done_cycle", dk, 12 + PB);

    // Back-to-back frames with load_valid held; garbage data while not ready.
`ifdef PISO_PARITY_EN
    bb = 18'b100000010_011111100;
`else
    bb = {2'b00, 16'b10000001_01111110};
`endif
    accept_word(8'h81);
    ndone = 0;
    for (int k = 1; k <= 2 * FL; k++) begin
      load_valid = (k <= FL);
      data_in    = (k == FL) ? 8'h7E : 8'hFF;
      sample();
      chk("b2b_valid", val_m, 1'b1);
      chk("b2b_bit", out_m, bb[2*FL-k]);
      if (done_m) ndone++;
      advance();
    end
    load_valid = 1'b0;
    sample();
    if (done_m) ndone++;
    advance();
    chk_int("b2b_done_count", ndone, 2);
    cycle();

    // Reset while bit 4 of 0xFF is on the line.
    accept_word(8'hFF);
    for (int k = 1; k <= 4; k++) cycle();
    reset_n = 1'b0;
    #1;
    chk("rst_valid", val_m, 1'b0);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_out", out_m, 1'b0);
    chk("rst_ready", rdy_m, 1'b1);
    chk("rst_done", done_m, 1'b0);
    chk("rst_valid_l", val_l, 1'b0);
    qm.delete();
    ql.delete();
    done_exp   = 1'b0;
    load_valid = 1'b1;
    data_in    = 8'hAA;
    for (int k = 0; k < 3; k++) cycle();
    load_valid = 1'b0;
    reset_n    = 1'b1;
    cycle();
    accept_word(8'h00);
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("rst_zero_valid", val_m, 1'b1);
      chk("rst_zero_bit", out_m, 1'b0);
      advance();
    end
    for (int k = 0; k < 3; k++) cycle();

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      load_valid = 1'($urandom_range(0, 1));
      shift_en   = ($urandom_range(0, 3) != 0);
      data_in    = 8'($urandom);
      cycle();
    end
    load_valid = 1'b0;
    shift_en   = 1'b1;
    for (int k = 0; k < 2 * FL; k++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_piso_serializer
